// File: rtl/factorial_scheduler.sv
// Round-robin front end sharing one factorial engine among N_REQ requesters.
// Jobs are serialized: grant, issue, wait for result or watchdog, respond.
module factorial_scheduler #(
    parameter  int N_REQ       = 4,
    parameter  int IN_DATA_WD  = 3,
    parameter  int OUT_DATA_WD = 16,
    parameter  int TIMEOUT     = 64,
    localparam int ID_WD       = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*IN_DATA_WD-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [OUT_DATA_WD-1:0]      rsp_data,
    output logic                        rsp_err,
    output logic [IN_DATA_WD-1:0]       eng_in_data,
    output logic                        eng_in_valid,
    input  logic [OUT_DATA_WD-1:0]      eng_out_data,
    input  logic                        eng_out_valid,
    input  logic                        eng_out_busy,
    output logic                        sched_busy
);

    localparam int TMR_WD = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ID_WD-1:0]       ptr;
    logic [ID_WD-1:0]       id_q;
    logic [ID_WD-1:0]       idx;
    logic [ID_WD-1:0]       grant_id;
    logic                   grant_found;
    logic [IN_DATA_WD-1:0]  operand_q;
    logic [TMR_WD-1:0]      timer;
    logic [OUT_DATA_WD-1:0] data_q;
    logic                   err_q;
    logic                   do_grant;
    logic                   rsp_accept;
    logic                   timer_expired;

    // First requesting index at or after ptr, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_WD'((int'(ptr) + i) % N_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // Reset gates the grant so req_ready drops the instant reset asserts.
    assign do_grant      = (state == S_IDLE) && grant_found && !eng_out_busy && !reset;
    assign rsp_accept    = (state == S_RESP) && rsp_ready[id_q];
    assign timer_expired = (timer == TMR_WD'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_data     = '0;
        rsp_err      = 1'b0;
        eng_in_data  = '0;
        eng_in_valid = 1'b0;
        sched_busy   = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (do_grant) begin
                    req_ready[grant_id] = 1'b1;
                    state_nxt           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_in_valid = 1'b1;
                eng_in_data  = operand_q;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (eng_out_valid || timer_expired) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[id_q] = 1'b1;
                rsp_data        = data_q;
                rsp_err         = err_q;
                if (rsp_accept) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            id_q      <= '0;
            operand_q <= '0;
            timer     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (do_grant) begin
                        id_q      <= grant_id;
                        operand_q <= req_data[int'(grant_id)*IN_DATA_WD +: IN_DATA_WD];
                    end
                end
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    // A result arriving on the expiry cycle still wins.
                    if (eng_out_valid) begin
                        data_q <= eng_out_data;
                        err_q  <= 1'b0;
                    end else if (timer_expired) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_accept) begin
                        ptr <= (id_q == ID_WD'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
